// File: rtl/dac_stream_arbiter.sv
// dac_stream_arbiter: round-robin, packet-locked AXI-Stream arbiter that shares
// one DAC sample stream between N_REQ requesters. The grant is held until a
// tlast beat or until MAX_BURST beats have passed, then re-arbitrated.
// Optional feature macro: DAC_PACE_EN inserts GAP_CYCLES idle cycles (GAP
// state) after every grant for DAC settling / LDAC time.
// Handshake: a beat transfers on the rising clk edge where tvalid && tready are
// both high; a source keeps tdata/tkeep/tlast stable while its tvalid is high,
// and tvalid never depends on tready.
module dac_stream_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_W     = 16,
   parameter int ID_W       = 2,
   parameter int MAX_BURST  = 64,
   parameter int GAP_CYCLES = 8
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [N_REQ*DATA_W-1:0]        s_tdata,
   input  logic [N_REQ*(DATA_W/8)-1:0]    s_tkeep,
   input  logic [N_REQ-1:0]               s_tvalid,
   input  logic [N_REQ-1:0]               s_tlast,
   output logic [N_REQ-1:0]               s_tready,
   output logic [DATA_W-1:0]              m_tdata,
   output logic [DATA_W/8-1:0]            m_tkeep,
   output logic                           m_tvalid,
   output logic                           m_tlast,
   output logic [ID_W-1:0]                m_tid,
   input  logic                           m_tready,
   output logic                           busy,
   output logic [1:0]                     dbg_state_o
);

   localparam int KW         = DATA_W / 8;
   localparam int CNT_W      = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
   localparam int BURST_LAST = (MAX_BURST > 0) ? MAX_BURST - 1 : 0;

`ifdef DAC_PACE_EN
   localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   typedef enum logic [1:0] {ARB = 2'd0, XFER = 2'd1, GAP = 2'd2} state_t;
   logic [GAP_W-1:0] gap_cnt_q;
`else
   typedef enum logic [1:0] {ARB = 2'd0, XFER = 2'd1} state_t;
`endif

   state_t            state_q;
   logic [ID_W-1:0]   grant_q;
   logic [ID_W-1:0]   last_grant_q;
   logic [ID_W-1:0]   m_tid_q;
   logic [CNT_W-1:0]  beat_cnt_q;

   logic              found_c;
   logic [ID_W-1:0]   next_grant_c;
   int                cand_c;
   logic [DATA_W-1:0] sel_data_c;
   logic [KW-1:0]     sel_keep_c;
   logic              sel_valid_c;
   logic              sel_last_c;
   logic              beat_c;
   logic              burst_end_c;
   logic              end_grant_c;

   // Round-robin pick: first valid requester scanning upward from last_grant+1.
   always_comb begin
      found_c      = 1'b0;
      next_grant_c = '0;
      cand_c       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand_c = (int'(last_grant_q) + k) % N_REQ;
         for (int i = 0; i < N_REQ; i++) begin
            if (!found_c && (i == cand_c) && s_tvalid[i]) begin
               found_c      = 1'b1;
               next_grant_c = ID_W'(i);
            end
         end
      end
   end

   // Pass-through mux from the granted requester (requester 0 while in reset).
   always_comb begin
      sel_data_c  = s_tdata[0 +: DATA_W];
      sel_keep_c  = s_tkeep[0 +: KW];
      sel_valid_c = s_tvalid[0];
      sel_last_c  = s_tlast[0];
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q == ID_W'(i)) begin
            sel_data_c  = s_tdata[i*DATA_W +: DATA_W];
            sel_keep_c  = s_tkeep[i*KW +: KW];
            sel_valid_c = s_tvalid[i];
            sel_last_c  = s_tlast[i];
         end
      end
   end

   // Only the granted requester sees m_tready, and only while transferring.
   always_comb begin
      s_tready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if ((state_q == XFER) && (grant_q == ID_W'(i))) s_tready[i] = m_tready;
      end
   end

   assign m_tdata     = sel_data_c;
   assign m_tkeep     = sel_keep_c;
   assign m_tlast     = sel_last_c;
   assign m_tvalid    = (state_q == XFER) && sel_valid_c;
   assign m_tid       = m_tid_q;
   assign busy        = (state_q != ARB);
   assign dbg_state_o = state_q;

   // A forced burst end leaves tlast untouched; the packet resumes at the next grant.
   assign beat_c      = m_tvalid && m_tready;
   assign burst_end_c = (MAX_BURST != 0) && (beat_cnt_q == CNT_W'(BURST_LAST));
   assign end_grant_c = beat_c && (m_tlast || burst_end_c);

   // Arbitration FSM: ARB -> XFER -> (GAP) -> ARB, grant and tag registered on entry to XFER.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ARB;
         grant_q      <= '0;
         last_grant_q <= ID_W'(N_REQ - 1);
         m_tid_q      <= '0;
         beat_cnt_q   <= '0;
`ifdef DAC_PACE_EN
         gap_cnt_q    <= '0;
`endif
      end else begin
         case (state_q)
            ARB: begin
               if (found_c) begin
                  grant_q      <= next_grant_c;
                  last_grant_q <= next_grant_c;
                  m_tid_q      <= next_grant_c;
                  beat_cnt_q   <= '0;
                  state_q      <= XFER;
               end
            end
            XFER: begin
               if (beat_c) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
                  if (end_grant_c) begin
`ifdef DAC_PACE_EN
                     if (GAP_CYCLES > 0) begin
                        gap_cnt_q <= GAP_W'(GAP_LOAD);
                        state_q   <= GAP;
                     end else begin
                        state_q   <= ARB;
                     end
`else
                     state_q <= ARB;
`endif
                  end
               end
            end
`ifdef DAC_PACE_EN
            GAP: begin
               if (gap_cnt_q == '0) state_q <= ARB;
               else gap_cnt_q <= gap_cnt_q - 1'b1;
            end
`endif
            default: state_q <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_stream_arbiter.sv
// Testbench for dac_stream_arbiter (N_REQ=4, DATA_W=16, MAX_BURST=4, GAP_CYCLES=8).
// Expected output beats come from a transaction-level round-robin model over
// per-requester packet queues; arbitration order is also covered by a table.
module tb_dac_stream_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int KW = DW / 8;
   localparam int IW = 2;
   localparam int MB = 4;
   localparam int EW = IW + KW + 1 + DW;
`ifdef DAC_PACE_EN
   localparam int GAP = 8;
`else
   localparam int GAP = 0;
`endif

   logic             clk = 1'b0;
   logic             resetn;
   logic [N*DW-1:0]  s_tdata;
   logic [N*KW-1:0]  s_tkeep;
   logic [N-1:0]     s_tvalid;
   logic [N-1:0]     s_tlast;
   logic [N-1:0]     s_tready;
   logic [DW-1:0]    m_tdata;
   logic [KW-1:0]    m_tkeep;
   logic             m_tvalid;
   logic             m_tlast;
   logic [IW-1:0]    m_tid;
   logic             m_tready;
   logic             busy;
   logic [1:0]       dbg_state;

   dac_stream_arbiter #(
      .N_REQ(N), .DATA_W(DW), .ID_W(IW), .MAX_BURST(MB), .GAP_CYCLES(8)
   ) dut (
      .clk(clk), .resetn(resetn),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
      .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
      .m_tlast(m_tlast), .m_tid(m_tid), .m_tready(m_tready),
      .busy(busy), .dbg_state_o(dbg_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_vec = 0;
   int n_bad = 0;
   int model_last = N - 1;

   logic [DW-1:0] rq_data[N][$];
   logic          rq_last[N][$];
   logic [EW-1:0] exp_q[$];

   typedef struct {
      logic [N-1:0]  mask;
      logic [IW-1:0] exp_id;
   } arb_vec_t;

   arb_vec_t arb_tab[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [KW-1:0] keep_of(input int i);
      return KW'(i) ^ 2'b10;
   endfunction

   // Driver: each requester presents the head of its queue, valid while non-empty
   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         s_tkeep[i*KW +: KW] = keep_of(i);
         if (rq_data[i].size() > 0) begin
            s_tvalid[i]        = 1'b1;
            s_tdata[i*DW +: DW] = rq_data[i][0];
            s_tlast[i]         = rq_last[i][0];
         end else begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
         end
      end
   endtask

   task automatic gen_packet(input int r, input int len, input logic [DW-1:0] base, input bit rnd);
      for (int k = 0; k < len; k++) begin
         rq_data[r].push_back(rnd ? DW'($urandom) : base + DW'(k));
         rq_last[r].push_back(k == len - 1);
      end
   endtask

   // Reference model: round-robin over non-empty queues, each grant ends on
   // tlast or after MB beats. Emits {id, keep, last, data} per output beat.
   task automatic build_expected();
      int pos[N];
      int idx;
      int c;
      int beats;
      bit done;
      for (int i = 0; i < N; i++) pos[i] = 0;
      while (1) begin
         idx = -1;
         for (int k = 1; k <= N; k++) begin
            c = (model_last + k) % N;
            if (idx < 0 && pos[c] < rq_data[c].size()) idx = c;
         end
         if (idx < 0) break;
         model_last = idx;
         beats = 0;
         done  = 1'b0;
         while (!done) begin
            exp_q.push_back({IW'(idx), keep_of(idx), rq_last[idx][pos[idx]], rq_data[idx][pos[idx]]});
            beats++;
            done = rq_last[idx][pos[idx]] || (MB != 0 && beats == MB) || (pos[idx] + 1 >= rq_data[idx].size());
            pos[idx]++;
         end
      end
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   // Stream engine: mode 0 ready=1, mode 1 random ready, mode 2 pattern 1,0,0,1
   task automatic run_stream(input int mode, input int max_cyc);
      logic [3:0]    pat = 4'b1001;
      logic [N-1:0]  hs;
      logic [N-1:0]  er;
      logic [EW-1:0] exp;
      int cyc = 0;
      build_expected();
      while (exp_q.size() > 0 && cyc < max_cyc) begin
         case (mode)
            0: m_tready = 1'b1;
            1: m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = pat[cyc % 4];
         endcase
         drive_inputs();
         @(negedge clk);
         er = '0;
         if (m_tvalid) er[exp_q[0][EW-1 -: IW]] = m_tready;
         check("s_tready", {28'd0, s_tready}, {28'd0, er});
         hs = s_tvalid & s_tready;
         if (m_tvalid && m_tready) begin
            exp = exp_q.pop_front();
            check("beat", {11'd0, m_tid, m_tkeep, m_tlast, m_tdata}, {11'd0, exp});
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
               void'(rq_data[i].pop_front());
               void'(rq_last[i].pop_front());
            end
         end
         cyc++;
      end
      check("stream_done", exp_q.size(), 0);
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         rq_data[i].delete();
         rq_last[i].delete();
      end
      drive_inputs();
      m_tready = 1'b1;
      wait_idle();
   endtask

   initial begin
      int n;
      // Clock/reset block
      resetn   = 1'b0;
      m_tready = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tvalid = '0;
      s_tlast  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("rst_s_tready", {28'd0, s_tready}, 32'd0);
      check("rst_m_tid",    {30'd0, m_tid}, 32'd0);
      check("rst_busy",     {31'd0, busy}, 32'd0);
      check("rst_state",    {30'd0, dbg_state}, 32'd0);
      resetn = 1'b1;
      wait_idle();

      // Requester 1: 0x1111/0x2222/0x3333 with tlast on beat 3
      rq_data[1].push_back(16'h1111); rq_last[1].push_back(1'b0);
      rq_data[1].push_back(16'h2222); rq_last[1].push_back(1'b0);
      rq_data[1].push_back(16'h3333); rq_last[1].push_back(1'b1);
      run_stream(0, 50);

      // Idle spacing after a tlast beat: GAP cycles with the pacing option, none without
      rq_data[0].push_back(16'hA5A5); rq_last[0].push_back(1'b1);
      m_tready = 1'b1;
      drive_inputs();
      @(posedge clk); #1;
      @(negedge clk);
      check("gap_pre_tid",   {30'd0, m_tid}, 32'd0);
      check("gap_pre_valid", {31'd0, m_tvalid}, 32'd1);
      check("gap_pre_data",  {16'd0, m_tdata}, 32'h0000A5A5);
      @(posedge clk); #1;
      void'(rq_data[0].pop_front());
      void'(rq_last[0].pop_front());
      drive_inputs();
      model_last = 0;
      n = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (!busy) break;
         if (!m_tvalid) n++;
      end
      check("gap_cycles", n, GAP);
      check("gap_end_busy", {31'd0, busy}, 32'd0);

      // Table: request masks (one-beat packets) and the expected grant
      arb_tab[0]  = '{4'b1111, 2'd1};
      arb_tab[1]  = '{4'b1111, 2'd2};
      arb_tab[2]  = '{4'b1111, 2'd3};
      arb_tab[3]  = '{4'b1111, 2'd0};
      arb_tab[4]  = '{4'b1111, 2'd1};
      arb_tab[5]  = '{4'b0101, 2'd2};
      arb_tab[6]  = '{4'b0101, 2'd0};
      arb_tab[7]  = '{4'b1000, 2'd3};
      arb_tab[8]  = '{4'b1000, 2'd3};
      arb_tab[9]  = '{4'b0011, 2'd0};
      arb_tab[10] = '{4'b0110, 2'd1};
      arb_tab[11] = '{4'b1001, 2'd3};
      arb_tab[12] = '{4'b0010, 2'd1};
      for (int r = 0; r < 13; r++) begin
         for (int i = 0; i < N; i++) begin
            s_tdata[i*DW +: DW] = 16'hC000 + DW'(i);
            s_tkeep[i*KW +: KW] = keep_of(i);
         end
         s_tvalid = arb_tab[r].mask;
         s_tlast  = '1;
         m_tready = 1'b1;
         @(posedge clk); #1;
         @(negedge clk);
         check("tab_tid",    {30'd0, m_tid}, {30'd0, arb_tab[r].exp_id});
         check("tab_valid",  {31'd0, m_tvalid}, 32'd1);
         check("tab_data",   {16'd0, m_tdata}, 32'hC000 + 32'(arb_tab[r].exp_id));
         check("tab_tready", {28'd0, s_tready}, 32'd1 << arb_tab[r].exp_id);
         @(posedge clk); #1;
         s_tvalid = '0;
         wait_idle();
         model_last = int'(arb_tab[r].exp_id);
      end

      // Burst limit: requester 2 sends 10 beats while requester 3 has two 1-beat packets
      gen_packet(2, 10, 16'h2000, 1'b0);
      gen_packet(3, 1, 16'h3000, 1'b0);
      gen_packet(3, 1, 16'h3001, 1'b0);
      run_stream(0, 100);

      // m_tready toggling 1,0,0,1 during a grant
      gen_packet(1, 3, 16'h4100, 1'b0);
      gen_packet(0, 2, 16'h4000, 1'b0);
      run_stream(2, 100);

      // Randomized traffic against the model
      for (int rnd = 0; rnd < 4; rnd++) begin
         for (int i = 0; i < N; i++) begin
            for (int p = 0; p < int'($urandom_range(0, 2)); p++)
               gen_packet(i, $urandom_range(1, 7), 16'h0, 1'b1);
         end
         run_stream(1, 3000);
      end

      // Reset on beat 2 of a 5-beat packet from requester 0
      s_tvalid = 4'b0001;
      s_tlast  = '0;
      s_tdata[0 +: DW] = 16'h5000;
      m_tready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstpkt_tid",   {30'd0, m_tid}, 32'd0);
      check("rstpkt_valid", {31'd0, m_tvalid}, 32'd1);
      @(posedge clk); #1;
      s_tdata[0 +: DW] = 16'h5001;
      resetn = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_valid",  {31'd0, m_tvalid}, 32'd0);
      check("rstmid_tready", {28'd0, s_tready}, 32'd0);
      check("rstmid_busy",   {31'd0, busy}, 32'd0);
      resetn   = 1'b1;
      s_tvalid = 4'b0011;
      s_tdata[0 +: DW]  = 16'h5000;
      s_tdata[DW +: DW] = 16'h5100;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstafter_tid",   {30'd0, m_tid}, 32'd0);
      check("rstafter_valid", {31'd0, m_tvalid}, 32'd1);
      check("rstafter_data",  {16'd0, m_tdata}, 32'h00005000);
      m_tready = 1'b0;
      s_tvalid = '0;

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
